// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - E-stage pipeline <-> multiply/divide unit signal bundle
interface mdu_ctrl_if;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        e_valid;
    logic        flush;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_is_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_data;

    modport master (
        output opcode, funct, e_valid, flush, rs_val, rt_val, d_is_md,
        input  busy, stall, hi, lo, mf_data
    );

    modport slave (
        input  opcode, funct, e_valid, flush, rs_val, rt_val, d_is_md,
        output busy, stall, hi, lo, mf_data
    );
endinterface

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - MIPS E-stage multiply/divide sequencer owning HI/LO
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    mdu_ctrl_if.slave mdu
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   pend_q, pend_d;
    logic          pend_wr_q, pend_wr_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;

    logic is_r, op_mfhi, op_mthi, op_mflo, op_mtlo;
    logic op_mult, op_multu, op_div, op_divu;
    logic op_start, op_any, go;

    assign is_r     = (mdu.opcode == 6'h00);
    assign op_mfhi  = is_r & (mdu.funct == 6'h10);
    assign op_mthi  = is_r & (mdu.funct == 6'h11);
    assign op_mflo  = is_r & (mdu.funct == 6'h12);
    assign op_mtlo  = is_r & (mdu.funct == 6'h13);
    assign op_mult  = is_r & (mdu.funct == 6'h18);
    assign op_multu = is_r & (mdu.funct == 6'h19);
    assign op_div   = is_r & (mdu.funct == 6'h1A);
    assign op_divu  = is_r & (mdu.funct == 6'h1B);
    assign op_start = op_mult | op_multu | op_div | op_divu;
    assign op_any   = op_start | op_mfhi | op_mthi | op_mflo | op_mtlo;
    assign go       = mdu.e_valid & ~mdu.flush & op_any;

    logic [63:0] prod_s, prod_u;
    assign prod_s = {{32{mdu.rs_val[31]}}, mdu.rs_val} * {{32{mdu.rt_val[31]}}, mdu.rt_val};
    assign prod_u = {32'd0, mdu.rs_val} * {32'd0, mdu.rt_val};

    // Signed divide runs on magnitudes so INT_MIN / -1 wraps to INT_MIN with remainder 0.
    logic [31:0] a_mag, b_mag, num, den, den_safe, q_u, r_u, quot, rem;
    assign a_mag    = mdu.rs_val[31] ? (~mdu.rs_val + 32'd1) : mdu.rs_val;
    assign b_mag    = mdu.rt_val[31] ? (~mdu.rt_val + 32'd1) : mdu.rt_val;
    assign num      = op_div ? a_mag : mdu.rs_val;
    assign den      = op_div ? b_mag : mdu.rt_val;
    assign den_safe = (den == 32'd0) ? 32'd1 : den;
    assign q_u      = num / den_safe;
    assign r_u      = num % den_safe;
    assign quot     = (op_div & (mdu.rs_val[31] ^ mdu.rt_val[31])) ? (~q_u + 32'd1) : q_u;
    assign rem      = (op_div & mdu.rs_val[31]) ? (~r_u + 32'd1) : r_u;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    if (op_mthi) hi_d = mdu.rs_val;
                    if (op_mtlo) lo_d = mdu.rs_val;
                    if (op_start) begin
                        state_d = S_BUSY;
                        if (op_mult | op_multu) begin
                            cnt_d     = CW'(MULT_CYCLES);
                            pend_d    = op_mult ? prod_s : prod_u;
                            pend_wr_d = 1'b1;
                        end else begin
                            cnt_d     = CW'(DIV_CYCLES);
                            pend_d    = {rem, quot};
                            // Divide by zero still occupies the unit but leaves HI/LO alone.
                            pend_wr_d = (mdu.rt_val != 32'd0);
                        end
                    end
                end
            end
            default: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign mdu.busy    = (state_q == S_BUSY);
    assign mdu.stall   = mdu.d_is_md & (mdu.busy | (go & op_start));
    assign mdu.hi      = hi_q;
    assign mdu.lo      = lo_q;
    assign mdu.mf_data = op_mfhi ? hi_q : (op_mflo ? lo_q : 32'd0);
endmodule
